// File: rtl/nibble_mul_seq_pkg.sv
// Shared definitions for the nibble-serial multiplier: nibble width, FSM
// state encoding and the nibble-count helper.
package nibble_mul_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int dw);
    return dw / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_mul_4x4.sv
// Combinational 4x4 unsigned array multiplier shared by the sequential
// controller; one instance serves every nibble pair.
module nibble_mul_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/nibble_mul_acc.sv
// Datapath: selects nibble i of a_op and nibble j of b_op, multiplies them
// in the shared 4x4 multiplier and shift-accumulates into a 2*DW sum.
module nibble_mul_acc
  import nibble_mul_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int IW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   a_op,
  input  logic [DW-1:0]   b_op,
  input  logic [IW-1:0]   i_idx,
  input  logic [IW-1:0]   j_idx,
  input  logic            clear,
  input  logic            enable,
  output logic [2*DW-1:0] acc_sum
);

  localparam int N     = nib_count(DW);
  localparam int SLOTS = 1 << IW;
  localparam int PW    = 2 * DW;
  localparam int SW    = $clog2(PW) + 1;

  // Nibble tables padded to a power of two so every index value is in range.
  logic [NIB_W-1:0] a_nib [SLOTS];
  logic [NIB_W-1:0] b_nib [SLOTS];

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_nib
      if (gi < N) begin : g_live
        assign a_nib[gi] = a_op[gi*NIB_W +: NIB_W];
        assign b_nib[gi] = b_op[gi*NIB_W +: NIB_W];
      end else begin : g_pad
        assign a_nib[gi] = '0;
        assign b_nib[gi] = '0;
      end
    end
  endgenerate

  logic [7:0]    pp;
  logic [PW-1:0] pp_ext;
  logic [SW-1:0] shamt;
  logic [PW-1:0] acc_reg;

  nibble_mul_4x4 u_mul (
    .a (a_nib[i_idx]),
    .b (b_nib[j_idx]),
    .p (pp)
  );

  assign pp_ext  = PW'(pp);
  assign shamt   = (SW'(i_idx) + SW'(j_idx)) << 2;
  // Cannot overflow: the full product always fits in 2*DW bits.
  assign acc_sum = acc_reg + (pp_ext << shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_sum;
    end
  end

endmodule

// File: rtl/nibble_mul_seq.sv
// Sequential DW x DW unsigned multiplier with valid/ready on both sides.
// Optional build macro MUL_ZERO_SKIP_EN: zero operands go straight to DONE.
module nibble_mul_seq
  import nibble_mul_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] p,
  output logic            busy
);

  localparam int N  = nib_count(DW);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t          state_reg, state_next;
  logic [DW-1:0]   a_reg, a_next;
  logic [DW-1:0]   b_reg, b_next;
  logic [IW-1:0]   i_reg, i_next;
  logic [IW-1:0]   j_reg, j_next;
  logic [2*DW-1:0] p_reg, p_next;
  logic [2*DW-1:0] acc_sum;
  logic            acc_clear;
  logic            acc_enable;

  nibble_mul_acc #(
    .DW (DW),
    .IW (IW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_op    (a_reg),
    .b_op    (b_reg),
    .i_idx   (i_reg),
    .j_idx   (j_reg),
    .clear   (acc_clear),
    .enable  (acc_enable),
    .acc_sum (acc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      p_reg     <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      p_reg     <= p_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    p_next     = p_reg;
    acc_clear  = 1'b0;
    acc_enable = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next    = a;
          b_next    = b;
          i_next    = '0;
          j_next    = '0;
          acc_clear = 1'b1;
`ifdef MUL_ZERO_SKIP_EN
          if (a == '0 || b == '0) begin
            p_next     = '0;
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
`else
          state_next = RUN;
`endif
        end
      end

      RUN: begin
        acc_enable = 1'b1;
        // j is the inner index; the last pair commits the sum to p.
        if (j_reg == IW'(N - 1)) begin
          j_next = '0;
          if (i_reg == IW'(N - 1)) begin
            i_next     = '0;
            p_next     = acc_sum;
            state_next = DONE;
          end else begin
            i_next = i_reg + 1'b1;
          end
        end else begin
          j_next = j_reg + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign p         = p_reg;

endmodule

// File: tb/tb_nibble_mul_seq.sv
// Scoreboard bench for nibble_mul_seq: directed vectors at DW=8 plus one
// full-scale DW=16 product on a second instance.
module tb_nibble_mul_seq;

  typedef struct {
    logic [15:0] p;
    int          lat;
  } exp_t;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        v16_in_valid, v16_in_ready, v16_out_valid, v16_busy;
  logic [15:0] v16_a, v16_b;
  logic [31:0] v16_p;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   seen_valid = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_mul_seq #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  nibble_mul_seq #(.DW(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16_in_valid),
    .in_ready  (v16_in_ready),
    .a         (v16_a),
    .b         (v16_b),
    .out_valid (v16_out_valid),
    .out_ready (1'b1),
    .p         (v16_p),
    .busy      (v16_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: each rising out_valid is one product, matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      seen_valid <= 1'b0;
    end else if (!seen_valid) begin
      seen_valid <= 1'b1;
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("product", p, mon_e.p);
        chk("latency", cyc - accept_cyc + 1, mon_e.lat);
        chk("in_ready_in_done", in_ready, 0);
        chk("busy_in_done", busy, 1);
        $display("txn p=0x%04h expected=0x%04h latency=%0d", p, mon_e.p, cyc - accept_cyc + 1);
      end
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] ep, input int lat);
    exp_t e;
    chk("in_ready_before_issue", in_ready, 1);
    e.p = ep;
    e.lat = lat;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    accept_cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk); #1;
    in_valid = 1'b0;
    a = ~ia;
    b = 8'h5A;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_timeout", n < 50, 1);
    chk("busy_after_handshake", busy, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    v16_in_valid = 1'b0; v16_a = '0; v16_b = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;

    issue(8'h12, 8'h34, 16'h03A8, 5);
    wait_done();
    issue(8'hFF, 8'hFF, 16'hFE01, 5);
    wait_done();

    // Backpressure: result must hold through six stalled cycles.
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 16'h03A8, 5);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("bp_rise", out_valid, 1);
    repeat (6) begin
      @(negedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_p", p, 16'h03A8);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);

    issue(8'h00, 8'h7F, 16'h0000, ZLAT);
    wait_done();

    // Requests offered while busy must be ignored.
    issue(8'h12, 8'h34, 16'h03A8, 5);
    in_valid = 1'b1; a = 8'h01; b = 8'h01;
    repeat (2) begin
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();
    repeat (8) begin
      @(negedge clk); #1;
    end

    // Reset during the second RUN cycle discards the pending result.
    issue(8'h12, 8'h34, 16'h03A8, 5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_p", p, 0);
    sb_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    issue(8'h03, 8'h05, 16'h000F, 5);
    wait_done();

    // Full-scale DW=16 product.
    chk("u16_in_ready", v16_in_ready, 1);
    v16_a = 16'hFFFF; v16_b = 16'hFFFF; v16_in_valid = 1'b1;
    @(negedge clk); #1;
    v16_in_valid = 1'b0;
    n = 1;
    while (!v16_out_valid && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("u16_latency", n, 17);
    chk("u16_p", v16_p, 32'hFFFE0001);
    $display("txn dw16 p=0x%08h latency=%0d", v16_p, n);

    repeat (4) begin
      @(negedge clk); #1;
    end
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
